vec_exec_ctrl: RTL and testbench
================================

Name: vec_exec_ctrl

Overview:
- Sequencing controller for the vector processor's execute path.
- Accepts one instruction at a time: LOAD, STORE, ADD, MUL.
- For ADD/MUL: reads vector registers A1/A2 (indices 0/1), drives the 16-lane 32-bit vector ALU, and writes the 1024-bit result back as two 512-bit halves into A3 (low) and A4 (high).
- For LOAD/STORE: moves one vector between the register file and the 32-bit-wide data memory, one word per beat.

Parameters:
- LANES, 16, number of 32-bit lanes per vector.
- LANE_W, 32, lane width in bits; VEC_W = LANES*LANE_W (512).
- MEM_AW, 9, data memory word-address width (512 words).
- REG_AW, 2, vector register index width (4 registers).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept; high only in IDLE.
- instr_op  in  2  00 LOAD, 01 STORE, 10 ADD, 11 MUL.
- instr_reg  in  REG_AW  LOAD destination / STORE source register.
- instr_addr  in  MEM_AW  LOAD/STORE base word address.
- rf_rd_idx  out  REG_AW  register-file read index (combinational read).
- rf_rd_data  in  VEC_W  register-file read data.
- rf_wr_en  out  1  register-file write strobe.
- rf_wr_idx  out  REG_AW  write index.
- rf_wr_data  out  VEC_W  write data.
- alu_in1  out  VEC_W  operand 1 (latched A1).
- alu_in2  out  VEC_W  operand 2 (latched A2).
- alu_op  out  1  0 add, 1 mul.
- alu_out  in  2*VEC_W  ALU result: lane i occupies bits [64i +: 64].
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  LANE_W  write word.
- mem_rdata  in  LANE_W  read word, valid exactly one cycle after a read strobe.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse coinciding with the final write of an instruction.

Behaviour:
- Reset values: all outputs 0, except instr_ready=1 once rst deasserts; state=IDLE; operand, result and beat registers cleared.
- Reset mid-operation: return to IDLE next edge; no further rf or mem writes; partial results are discarded.
- Handshake: instruction accepted on the cycle where instr_valid && instr_ready; op/reg/addr latched that cycle. No further accept until return to IDLE.
- States:
  - IDLE
  - RD_A, RD_B, EXEC, WB_LO, WB_HI
  - LD_BEAT, LD_DRAIN, LD_WB
  - ST_RD, ST_BEAT
- ADD/MUL path (accept = cycle 0):
  - c1 RD_A: rf_rd_idx=0, latch A1.
  - c2 RD_B: rf_rd_idx=1, latch A2.
  - c3 EXEC: alu_in1/alu_in2 stable, alu_op driven; alu_out registered.
  - c4 WB_LO: write idx 2 with res[511:0].
  - c5 WB_HI: write idx 3 with res[1023:512]; done=1.
  - c6: IDLE.
- alu_in1, alu_in2 and alu_op hold their values until the next ADD/MUL reaches RD_A.
- LOAD path:
  - LD_BEAT, cycles 1..16: beat k issues a read at mem_addr=(base+k) mod 2^MEM_AW.
  - mem_rdata for beat k is captured into buffer bits [32k +: 32] in the following cycle; LD_DRAIN (c17) captures beat 15.
  - c18 LD_WB: write instr_reg with the buffer; done=1.
- STORE path:
  - c1 ST_RD: rf_rd_idx=instr_reg, latch vector.
  - ST_BEAT, cycles 2..17: beat k writes buffer[32k +: 32] to (base+k) mod 2^MEM_AW.
  - done=1 with beat 15.
- Address wrap: base 505 hits 505..511, then 0..8.
- rf_wr_en and mem_we are never high in the same cycle.
- mem_en=0 outside beat states.
- LOAD into index 0/1 is legal; a following ADD/MUL uses the new value.

Decomposition:
- Package vp_pkg: opcode enum (OP_LOAD, OP_STORE, OP_ADD, OP_MUL), state enum, LANES/LANE_W/VEC_W/MEM_AW constants, fixed register indices (A1=0, A2=1, A3=2, A4=3).
- One sub-module: vec_beat_seq. It holds the 4-bit beat counter, the last-beat flag and wrapped address generation, and is shared by the LOAD and STORE paths.

Test Plan:
- ADD: A1 lanes all 0x7FFFFFFF, A2 lanes all 1 -> A3 = eight 64-bit lanes of 0x0000_0000_8000_0000, A4 same for lanes 8..15; done at cycle 5; instr_ready low for cycles 1..5.
- MUL: lane0 -2 × 3, other lanes 0 -> A3[63:0]=0xFFFF_FFFF_FFFF_FFFA, all other bits 0; alu_op=1 during EXEC.
- LOAD reg1 from base 505, mem[a]=a -> A2 lane k = (505+k) mod 512 (lane 7 = 0); rf write at cycle 18 only.
- STORE reg2 to base 0 -> mem[k] = A3 lane k for k=0..15; mem[16] unchanged; done with the 16th write.
- Reset asserted at cycle 3 of a LOAD -> no rf write occurs; busy=0 and instr_ready=1 on the first cycle after rst drops; a subsequent ADD completes normally.
- Back-to-back: instr_valid held high with 2 queued ops -> second accepted exactly one cycle after the first op's done.

Source files
------------

// File: rtl/vp_pkg.sv
// rtl/vp_pkg.sv - shared constants, opcode and state encodings for the vector execute controller
package vp_pkg;

    localparam int LANES   = 16;
    localparam int LANE_W  = 32;
    localparam int VEC_W   = LANES * LANE_W;
    localparam int MEM_AW  = 9;
    localparam int REG_AW  = 2;
    localparam int BEAT_W  = $clog2(LANES);
    localparam int LANE_SH = $clog2(LANE_W);

    localparam logic [REG_AW-1:0] REG_A1 = 2'd0;
    localparam logic [REG_AW-1:0] REG_A2 = 2'd1;
    localparam logic [REG_AW-1:0] REG_A3 = 2'd2;
    localparam logic [REG_AW-1:0] REG_A4 = 2'd3;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_ADD   = 2'b10,
        OP_MUL   = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_EXEC,
        S_WB_LO,
        S_WB_HI,
        S_LD_BEAT,
        S_LD_DRAIN,
        S_LD_WB,
        S_ST_RD,
        S_ST_BEAT
    } state_e;

endpackage

// File: rtl/vec_beat_seq.sv
// rtl/vec_beat_seq.sv - beat counter, last-beat flag and wrapped word address for LOAD/STORE
module vec_beat_seq
    import vp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_adv,
    input  logic [MEM_AW-1:0] i_base,
    output logic [BEAT_W-1:0] o_beat,
    output logic              o_last,
    output logic [MEM_AW-1:0] o_addr
);

    logic [BEAT_W-1:0] r_beat;
    logic [MEM_AW-1:0] r_base;

    // Capture the base address on instruction accept, then step one beat per advance.
    // The counter wraps 15 -> 0 on the last beat, which the LOAD drain relies on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
            r_base <= '0;
        end else if (i_start) begin
            r_beat <= '0;
            r_base <= i_base;
        end else if (i_adv) begin
            r_beat <= r_beat + 1'b1;
        end
    end

    assign o_beat = r_beat;
    assign o_last = (r_beat == BEAT_W'(LANES - 1));
    // Natural truncation to MEM_AW bits gives the modulo wrap of the data memory.
    assign o_addr = r_base + MEM_AW'(r_beat);

endmodule

// File: rtl/vec_exec_ctrl.sv
// rtl/vec_exec_ctrl.sv - execute-path sequencer for LOAD/STORE/ADD/MUL on the vector register file
module vec_exec_ctrl
    import vp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [1:0]          instr_op,
    input  logic [REG_AW-1:0]   instr_reg,
    input  logic [MEM_AW-1:0]   instr_addr,
    output logic [REG_AW-1:0]   rf_rd_idx,
    input  logic [VEC_W-1:0]    rf_rd_data,
    output logic                rf_wr_en,
    output logic [REG_AW-1:0]   rf_wr_idx,
    output logic [VEC_W-1:0]    rf_wr_data,
    output logic [VEC_W-1:0]    alu_in1,
    output logic [VEC_W-1:0]    alu_in2,
    output logic                alu_op,
    input  logic [2*VEC_W-1:0]  alu_out,
    output logic                mem_en,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [LANE_W-1:0]   mem_wdata,
    input  logic [LANE_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                done
);

    state_e                      r_state;
    state_e                      w_state_nxt;
    op_e                         r_op;
    op_e                         w_op_in;
    logic [REG_AW-1:0]           r_reg;
    logic [VEC_W-1:0]            r_op1;
    logic [VEC_W-1:0]            r_op2;
    logic                        r_alu_op;
    logic [2*VEC_W-1:0]          r_res;
    logic [VEC_W-1:0]            r_buf;

    logic                        w_accept;
    logic                        w_seq_start;
    logic                        w_seq_adv;
    logic [BEAT_W-1:0]           w_beat;
    logic [BEAT_W-1:0]           w_cap_beat;
    logic                        w_last;
    logic [MEM_AW-1:0]           w_seq_addr;
    logic [BEAT_W+LANE_SH-1:0]   w_beat_off;
    logic [BEAT_W+LANE_SH-1:0]   w_cap_off;

    assign w_op_in    = op_e'(instr_op);
    // Read data returns one cycle late, so the capture slot trails the issuing beat by one.
    assign w_cap_beat = w_beat - 1'b1;
    assign w_beat_off = {w_beat, {LANE_SH{1'b0}}};
    assign w_cap_off  = {w_cap_beat, {LANE_SH{1'b0}}};

    assign alu_in1 = r_op1;
    assign alu_in2 = r_op2;
    assign alu_op  = r_alu_op;

    vec_beat_seq u_beat_seq (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_seq_start),
        .i_adv   (w_seq_adv),
        .i_base  (instr_addr),
        .o_beat  (w_beat),
        .o_last  (w_last),
        .o_addr  (w_seq_addr)
    );

    // State register; reset always lands in IDLE on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath capture: instruction fields, operands, ALU result and the per-beat vector buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_LOAD;
            r_reg    <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_alu_op <= 1'b0;
            r_res    <= '0;
            r_buf    <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= w_op_in;
                r_reg <= instr_reg;
            end
            case (r_state)
                S_RD_A: begin
                    r_op1    <= rf_rd_data;
                    r_alu_op <= (r_op == OP_MUL);
                end
                S_RD_B:     r_op2 <= rf_rd_data;
                S_EXEC:     r_res <= alu_out;
                S_LD_BEAT: begin
                    if (w_beat != '0) begin
                        r_buf[w_cap_off +: LANE_W] <= mem_rdata;
                    end
                end
                S_LD_DRAIN: r_buf[w_cap_off +: LANE_W] <= mem_rdata;
                S_ST_RD:    r_buf <= rf_rd_data;
                default: ;
            endcase
        end
    end

    // Next-state and strobe decode; write strobes and handshakes are suppressed while rst is high.
    always_comb begin
        w_state_nxt = r_state;
        instr_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        rf_rd_idx   = REG_A1;
        rf_wr_en    = 1'b0;
        rf_wr_idx   = '0;
        rf_wr_data  = '0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        w_accept    = 1'b0;
        w_seq_start = 1'b0;
        w_seq_adv   = 1'b0;

        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_accept    = 1'b1;
                    w_seq_start = 1'b1;
                    case (w_op_in)
                        OP_LOAD:  w_state_nxt = S_LD_BEAT;
                        OP_STORE: w_state_nxt = S_ST_RD;
                        default:  w_state_nxt = S_RD_A;
                    endcase
                end
            end
            S_RD_A: begin
                rf_rd_idx   = REG_A1;
                w_state_nxt = S_RD_B;
            end
            S_RD_B: begin
                rf_rd_idx   = REG_A2;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = S_WB_LO;
            end
            S_WB_LO: begin
                rf_wr_en    = 1'b1;
                rf_wr_idx   = REG_A3;
                rf_wr_data  = r_res[VEC_W-1:0];
                w_state_nxt = S_WB_HI;
            end
            S_WB_HI: begin
                rf_wr_en    = 1'b1;
                rf_wr_idx   = REG_A4;
                rf_wr_data  = r_res[2*VEC_W-1:VEC_W];
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_LD_BEAT: begin
                mem_en    = 1'b1;
                mem_addr  = w_seq_addr;
                w_seq_adv = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_LD_DRAIN;
                end
            end
            S_LD_DRAIN: begin
                w_state_nxt = S_LD_WB;
            end
            S_LD_WB: begin
                rf_wr_en    = 1'b1;
                rf_wr_idx   = r_reg;
                rf_wr_data  = r_buf;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_ST_RD: begin
                rf_rd_idx   = r_reg;
                w_state_nxt = S_ST_BEAT;
            end
            S_ST_BEAT: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_seq_addr;
                mem_wdata = r_buf[w_beat_off +: LANE_W];
                w_seq_adv = 1'b1;
                if (w_last) begin
                    done        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        busy = (r_state != S_IDLE);

        if (rst) begin
            instr_ready = 1'b0;
            busy        = 1'b0;
            done        = 1'b0;
            rf_wr_en    = 1'b0;
            mem_en      = 1'b0;
            mem_we      = 1'b0;
            w_accept    = 1'b0;
            w_seq_start = 1'b0;
            w_seq_adv   = 1'b0;
        end
    end

endmodule

// File: tb/tb_vec_exec_ctrl.sv
// tb/tb_vec_exec_ctrl.sv - randomized self-checking bench for vec_exec_ctrl with behavioural reference model
module tb_vec_exec_ctrl;

    logic           clk = 1'b0;
    logic           rst;
    logic           instr_valid;
    logic           instr_ready;
    logic [1:0]     instr_op;
    logic [1:0]     instr_reg;
    logic [8:0]     instr_addr;
    logic [1:0]     rf_rd_idx;
    logic [511:0]   rf_rd_data;
    logic           rf_wr_en;
    logic [1:0]     rf_wr_idx;
    logic [511:0]   rf_wr_data;
    logic [511:0]   alu_in1;
    logic [511:0]   alu_in2;
    logic           alu_op;
    logic [1023:0]  alu_out;
    logic           mem_en;
    logic           mem_we;
    logic [8:0]     mem_addr;
    logic [31:0]    mem_wdata;
    logic [31:0]    mem_rdata;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    vec_exec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_reg   (instr_reg),
        .instr_addr  (instr_addr),
        .rf_rd_idx   (rf_rd_idx),
        .rf_rd_data  (rf_rd_data),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_idx   (rf_wr_idx),
        .rf_wr_data  (rf_wr_data),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .done        (done)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Lane-wise signed 32x32 -> 64 ALU: lane i result in bits [64i +: 64].
    function automatic logic [1023:0] alu_ref(input logic [511:0] a, input logic [511:0] b, input logic mul);
        logic [1023:0]      r;
        logic signed [63:0] x;
        logic signed [63:0] y;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            x = {{32{a[32*i+31]}}, a[32*i +: 32]};
            y = {{32{b[32*i+31]}}, b[32*i +: 32]};
            r[64*i +: 64] = mul ? (x * y) : (x + y);
        end
        return r;
    endfunction

    function automatic logic [31:0] mem_init_val(input int a, input logic [31:0] seed);
        if (seed == 32'd0) return 32'(a);
        return (32'(a) * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- environment: register file, data memory, ALU ----------------
    logic [511:0] env_rf  [4];
    logic [31:0]  env_mem [512];
    logic [31:0]  mem_rdata_r;
    logic         pl_en = 1'b0;
    logic [1:0]   pl_idx = '0;
    logic [511:0] pl_data = '0;
    logic         mem_init_en = 1'b0;
    logic [31:0]  mem_seed = '0;

    assign rf_rd_data = env_rf[rf_rd_idx];
    assign mem_rdata  = mem_rdata_r;
    assign alu_out    = alu_ref(alu_in1, alu_in2, alu_op);

    always @(posedge clk) begin
        if (pl_en) env_rf[pl_idx] <= pl_data;
        else if (rf_wr_en) env_rf[rf_wr_idx] <= rf_wr_data;
        if (mem_init_en) begin
            for (int a = 0; a < 512; a++) env_mem[a] <= mem_init_val(a, mem_seed);
        end else if (mem_en && mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_we) mem_rdata_r <= env_mem[mem_addr];
    end

    // ---------------- behavioural reference model + per-cycle compare ----------------
    logic [511:0] m_rf  [4];
    logic [31:0]  m_mem [512];
    logic         m_active = 1'b0;
    int           m_p = 0;
    int           m_len = 0;
    logic [1:0]   m_op = '0;
    logic [1:0]   m_reg = '0;
    logic [8:0]   m_base = '0;
    int           acc_hist[$];
    int           done_hist[$];

    always @(negedge clk) begin : cmp
        logic          e_ready, e_busy, e_done, e_wr, e_men, e_mwe, e_rd_chk, e_alu_chk;
        logic [1:0]    e_wr_idx, e_rd_idx;
        logic [511:0]  e_wr_data;
        logic [8:0]    e_maddr;
        logic [31:0]   e_mwdata;
        logic [1023:0] res;
        int            k;
        cyc++;
        if (pl_en) m_rf[pl_idx] = pl_data;
        if (mem_init_en) begin
            for (int a = 0; a < 512; a++) m_mem[a] = mem_init_val(a, mem_seed);
        end
        if (rst) begin
            chk("rst_instr_ready", {511'b0, instr_ready}, 512'd0);
            chk("rst_busy",        {511'b0, busy},        512'd0);
            chk("rst_rf_wr_en",    {511'b0, rf_wr_en},    512'd0);
            chk("rst_mem_en",      {511'b0, mem_en},      512'd0);
            chk("rst_done",        {511'b0, done},        512'd0);
            m_active = 1'b0;
        end else begin
            e_ready = !m_active; e_busy = m_active; e_done = 1'b0;
            e_wr = 1'b0; e_wr_idx = '0; e_wr_data = '0;
            e_men = 1'b0; e_mwe = 1'b0; e_maddr = '0; e_mwdata = '0;
            e_rd_chk = 1'b0; e_rd_idx = '0; e_alu_chk = 1'b0;
            if (m_active) begin
                if (m_op[1]) begin
                    res = alu_ref(m_rf[0], m_rf[1], m_op == 2'b11);
                    case (m_p)
                        1: begin e_rd_chk = 1'b1; e_rd_idx = 2'd0; end
                        2: begin e_rd_chk = 1'b1; e_rd_idx = 2'd1; end
                        3: e_alu_chk = 1'b1;
                        4: begin e_wr = 1'b1; e_wr_idx = 2'd2; e_wr_data = res[511:0]; end
                        5: begin e_wr = 1'b1; e_wr_idx = 2'd3; e_wr_data = res[1023:512]; e_done = 1'b1; end
                        default: ;
                    endcase
                end else if (m_op == 2'b00) begin
                    if (m_p <= 16) begin
                        e_men = 1'b1;
                        e_maddr = 9'((int'(m_base) + m_p - 1) % 512);
                    end
                    if (m_p == 18) begin
                        e_wr = 1'b1; e_wr_idx = m_reg; e_done = 1'b1;
                        for (int j = 0; j < 16; j++) e_wr_data[32*j +: 32] = m_mem[(int'(m_base) + j) % 512];
                    end
                end else begin
                    if (m_p == 1) begin e_rd_chk = 1'b1; e_rd_idx = m_reg; end
                    if (m_p >= 2) begin
                        k = m_p - 2;
                        e_men = 1'b1; e_mwe = 1'b1;
                        e_maddr = 9'((int'(m_base) + k) % 512);
                        e_mwdata = m_rf[m_reg][32*k +: 32];
                        e_done = (k == 15);
                    end
                end
            end
            chk("instr_ready", {511'b0, instr_ready}, {511'b0, e_ready});
            chk("busy",        {511'b0, busy},        {511'b0, e_busy});
            chk("done",        {511'b0, done},        {511'b0, e_done});
            chk("rf_wr_en",    {511'b0, rf_wr_en},    {511'b0, e_wr});
            chk("mem_en",      {511'b0, mem_en},      {511'b0, e_men});
            chk("mem_we",      {511'b0, mem_we},      {511'b0, e_mwe});
            if (e_wr) begin
                chk("rf_wr_idx",  {510'b0, rf_wr_idx}, {510'b0, e_wr_idx});
                chk("rf_wr_data", rf_wr_data, e_wr_data);
                m_rf[e_wr_idx] = e_wr_data;
            end
            if (e_men) chk("mem_addr", {503'b0, mem_addr}, {503'b0, e_maddr});
            if (e_mwe) begin
                chk("mem_wdata", {480'b0, mem_wdata}, {480'b0, e_mwdata});
                m_mem[e_maddr] = e_mwdata;
            end
            if (e_rd_chk) chk("rf_rd_idx", {510'b0, rf_rd_idx}, {510'b0, e_rd_idx});
            if (e_alu_chk) begin
                chk("alu_op",  {511'b0, alu_op}, {511'b0, (m_op == 2'b11)});
                chk("alu_in1", alu_in1, m_rf[0]);
                chk("alu_in2", alu_in2, m_rf[1]);
            end
            if (done) done_hist.push_back(cyc);
            if (instr_valid && instr_ready) acc_hist.push_back(cyc);
            if (m_active) begin
                if (m_p == m_len) m_active = 1'b0;
                else m_p++;
            end else if (instr_valid) begin
                m_active = 1'b1; m_p = 1;
                m_op = instr_op; m_reg = instr_reg; m_base = instr_addr;
                m_len = instr_op[1] ? 5 : (instr_op == 2'b00 ? 18 : 17);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic preload(input logic [1:0] idx, input logic [511:0] d);
        pl_en = 1'b1; pl_idx = idx; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic init_mem(input logic [31:0] seed);
        mem_init_en = 1'b1; mem_seed = seed;
        @(posedge clk); #1;
        mem_init_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] r, input logic [8:0] a);
        int g;
        g = 0;
        instr_op = op; instr_reg = r; instr_addr = a; instr_valid = 1'b1;
        @(negedge clk);
        while (!instr_ready && g < 100) begin @(negedge clk); g++; end
        chk("issue_ready_timeout", {511'b0, instr_ready}, 512'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 100) begin @(negedge clk); g++; end
        chk("idle_timeout", {511'b0, busy}, 512'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [511:0] rand_vec();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 4))
                0: v[32*i +: 32] = 32'h7FFF_FFFF;
                1: v[32*i +: 32] = 32'h8000_0000;
                2: v[32*i +: 32] = 32'hFFFF_FFFF;
                default: v[32*i +: 32] = $urandom;
            endcase
        end
        return v;
    endfunction

    // ---------------- main sequence ----------------
    logic [511:0] pat;

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_reg = '0; instr_addr = '0;
        @(posedge clk); #1;
        init_mem(32'd0);
        preload(2'd0, {16{32'h7FFF_FFFF}});
        preload(2'd1, {16{32'h0000_0001}});
        preload(2'd2, '0);
        preload(2'd3, '0);
        rst = 1'b0;

        // ADD: saturating-edge lanes
        issue(2'b10, 2'd0, 9'd0);
        wait_idle();
        chk("add_a3", env_rf[2], {8{64'h0000_0000_8000_0000}});
        chk("add_a4", env_rf[3], {8{64'h0000_0000_8000_0000}});
        chk("add_latency", 512'(done_hist[$] - acc_hist[$]), 512'd5);

        // MUL: -2 x 3 in lane 0 only
        preload(2'd0, {480'b0, 32'hFFFF_FFFE});
        preload(2'd1, {480'b0, 32'h0000_0003});
        issue(2'b11, 2'd0, 9'd0);
        wait_idle();
        chk("mul_a3", env_rf[2], {448'b0, 64'hFFFF_FFFF_FFFF_FFFA});
        chk("mul_a4", env_rf[3], 512'd0);

        // LOAD reg1 from 505 with address wrap
        issue(2'b00, 2'd1, 9'd505);
        wait_idle();
        chk("load_lane0",  {480'b0, env_rf[1][31:0]},    512'd505);
        chk("load_lane7",  {480'b0, env_rf[1][255:224]}, 512'd0);
        chk("load_lane15", {480'b0, env_rf[1][511:480]}, 512'd8);
        chk("load_latency", 512'(done_hist[$] - acc_hist[$]), 512'd18);

        // STORE reg2 (MUL result) to base 0
        issue(2'b01, 2'd2, 9'd0);
        wait_idle();
        chk("store_mem0",  {480'b0, env_mem[0]},  {480'b0, 32'hFFFF_FFFA});
        chk("store_mem1",  {480'b0, env_mem[1]},  {480'b0, 32'hFFFF_FFFF});
        chk("store_mem15", {480'b0, env_mem[15]}, 512'd0);
        chk("store_mem16", {480'b0, env_mem[16]}, 512'd16);
        chk("store_latency", 512'(done_hist[$] - acc_hist[$]), 512'd17);

        // Reset at cycle 3 of a LOAD
        pat = {16{32'hA5A5_0003}};
        preload(2'd3, pat);
        issue(2'b00, 2'd3, 9'd100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy",  {511'b0, busy},        512'd0);
        chk("post_rst_ready", {511'b0, instr_ready}, 512'd1);
        @(posedge clk); #1;
        chk("rst_no_rf_write", env_rf[3], pat);
        issue(2'b10, 2'd0, 9'd0);
        wait_idle();
        chk("post_rst_add_latency", 512'(done_hist[$] - acc_hist[$]), 512'd5);

        // Back-to-back with instr_valid held
        issue(2'b10, 2'd0, 9'd0);
        issue(2'b11, 2'd0, 9'd0);
        wait_idle();
        chk("b2b_gap", 512'(acc_hist[$] - done_hist[$-1]), 512'd1);

        // Randomized phase
        init_mem($urandom | 32'd1);
        for (int i = 0; i < 4; i++) preload(2'(i), rand_vec());
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if ($urandom_range(0, 5) == 0) preload(2'($urandom_range(0, 3)), rand_vec());
            issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)));
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 19)) begin @(posedge clk); #1; end
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end
            wait_idle();
        end

        // Final state agreement between environment storage and the model
        for (int i = 0; i < 4; i++) chk("final_rf", env_rf[i], m_rf[i]);
        for (int a = 0; a < 512; a++) chk("final_mem", {480'b0, env_mem[a]}, {480'b0, m_mem[a]});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
